// File: rtl/iir_par_inv.sv
// rtl/iir_par_inv.sv - inverse of the two-phase IIR y[n] = x[n] + 0.75*y[n-2]
module iir_par_inv #(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W:0]   y_in,
    input  logic                in_valid,
    output logic signed [W:0]   x_out,
    output logic                out_valid,
    output logic                out_phase
);

    // Demux state: which phase the next accepted sample belongs to.
    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    // Saturation bounds expressed in the widened (W+3 bit) arithmetic domain.
    localparam logic signed [W+2:0] SAT_MAX = {3'b000, {W{1'b1}}};
    localparam logic signed [W+2:0] SAT_MIN = {3'b111, {W{1'b0}}};

    state_t state;
    state_t state_next;

    // Pending even sample and the previous pair's history, one per phase.
    logic signed [W:0] ye;
    logic signed [W:0] ye_d;
    logic signed [W:0] yo_d;

    // Results of the most recently completed pair, waiting to be emitted.
    logic signed [W:0] even_buf;
    logic signed [W:0] odd_buf;
    logic              even_pend;
    logic              odd_pend;

    logic              ye_load;
    logic              pair_done;
    logic signed [W:0] even_res;
    logic signed [W:0] odd_res;

    // x = y - (yd >>> 1) - (yd >>> 2) in W+3 bits, then clamp to the sample range.
    function automatic logic signed [W:0] inv_sat(
        input logic signed [W:0] y,
        input logic signed [W:0] yd
    );
        logic signed [W+2:0] y_w;
        logic signed [W+2:0] yd_w;
        logic signed [W+2:0] sum;
        y_w  = {{2{y[W]}}, y};
        yd_w = {{2{yd[W]}}, yd};
        sum  = y_w - (yd_w >>> 1) - (yd_w >>> 2);
        if (sum > SAT_MAX) begin
            inv_sat = SAT_MAX[W:0];
        end else if (sum < SAT_MIN) begin
            inv_sat = SAT_MIN[W:0];
        end else begin
            inv_sat = sum[W:0];
        end
    endfunction

    // Next-state and per-edge control: toggle phase only on accepted samples.
    always_comb begin
        state_next = state;
        ye_load    = 1'b0;
        pair_done  = 1'b0;
        if (in_valid) begin
            case (state)
                EVEN: begin
                    ye_load    = 1'b1;
                    state_next = ODD;
                end
                ODD: begin
                    pair_done  = 1'b1;
                    state_next = EVEN;
                end
                default: state_next = EVEN;
            endcase
        end
    end

    // Phase results: the even result only sees even history, the odd only odd.
    always_comb begin
        even_res = inv_sat(ye, ye_d);
        odd_res  = inv_sat(y_in, yo_d);
    end

    // State register, sample capture and pair history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EVEN;
            ye       <= '0;
            ye_d     <= '0;
            yo_d     <= '0;
            even_buf <= '0;
            odd_buf  <= '0;
        end else begin
            state <= state_next;
            if (ye_load) begin
                ye <= y_in;
            end
            if (pair_done) begin
                even_buf <= even_res;
                odd_buf  <= odd_res;
                ye_d     <= ye;
                yo_d     <= y_in;
            end
        end
    end

    // Output sequencing: even result on the edge after a pair, odd one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            even_pend <= 1'b0;
            odd_pend  <= 1'b0;
            x_out     <= '0;
            out_valid <= 1'b0;
            out_phase <= 1'b0;
        end else begin
            even_pend <= pair_done;
            odd_pend  <= even_pend;
            out_valid <= 1'b0;
            if (even_pend) begin
                x_out     <= even_buf;
                out_phase <= 1'b0;
                out_valid <= 1'b1;
            end else if (odd_pend) begin
                x_out     <= odd_buf;
                out_phase <= 1'b1;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_par_inv.sv
// tb/tb_iir_par_inv.sv - self-checking bench for iir_par_inv against a sample-level model
module tb_iir_par_inv;

    localparam int W    = 14;
    localparam int XMAX = (1 << W) - 1;
    localparam int XMIN = -(1 << W);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [W:0]   y_in = '0;
    logic                in_valid = 1'b0;
    logic signed [W:0]   x_out;
    logic                out_valid;
    logic                out_phase;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: accepted samples since reset, and outputs scheduled for the next two edges.
    int ys[$];
    int got[$];
    bit slot_v[2];
    int slot_x[2];
    bit slot_p[2];
    int last_x = 0;
    bit last_p = 1'b0;

    iir_par_inv #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .x_out     (x_out),
        .out_valid (out_valid),
        .out_phase (out_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // x[n] = y[n] - 0.75*y[n-2] with floor on each term, clamped to the sample range.
    function automatic int model_x(input int n);
        int ym2;
        int r;
        ym2 = (n >= 2) ? ys[n-2] : 0;
        r = ys[n] - floor_div(ym2, 2) - floor_div(ym2, 4);
        if (r > XMAX) r = XMAX;
        if (r < XMIN) r = XMIN;
        return r;
    endfunction

    // One clock edge: drive inputs, advance the model, compare outputs just after the edge.
    task automatic step(input bit r, input bit v, input int yv);
        bit ev;
        int ex;
        bit ep;
        int n;
        reset    = r;
        in_valid = v;
        y_in     = yv[W:0];
        @(posedge clk);
        #1;
        if (r) begin
            ev = 1'b0; ex = 0; ep = 1'b0;
            ys.delete();
            slot_v[0] = 1'b0; slot_v[1] = 1'b0;
            last_x = 0; last_p = 1'b0;
        end else begin
            ev = slot_v[0]; ex = slot_x[0]; ep = slot_p[0];
            slot_v[0] = slot_v[1]; slot_x[0] = slot_x[1]; slot_p[0] = slot_p[1];
            slot_v[1] = 1'b0;
            if (v) begin
                ys.push_back(yv);
                if (ys.size() % 2 == 0) begin
                    n = ys.size() - 2;
                    slot_v[0] = 1'b1; slot_x[0] = model_x(n);     slot_p[0] = 1'b0;
                    slot_v[1] = 1'b1; slot_x[1] = model_x(n + 1); slot_p[1] = 1'b1;
                end
            end
            if (!ev) begin
                ex = last_x;
                ep = last_p;
            end
        end
        check("out_valid", int'(out_valid), int'(ev));
        check("x_out", int'(x_out), ex);
        check("out_phase", int'(out_phase), int'(ep));
        if (out_valid) got.push_back(int'(x_out));
        last_x = ex;
        last_p = ep;
    endtask

    task automatic feed(input int yv);
        step(1'b0, 1'b1, yv);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0);
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 0);
        got.delete();
    endtask

    task automatic expect_seq(input string tag, input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(tag, got[i], exp[i]);
        end
    endtask

    initial begin
        int yv;
        // Reset state, including reset arriving together with a valid sample.
        step(1'b1, 1'b1, 123);
        step(1'b1, 1'b0, 0);
        got.delete();

        // Impulse with continuous valid.
        feed(1000); feed(0); feed(0); feed(0); feed(0); feed(0); idle(); idle();
        expect_seq("impulse", '{1000, 0, -750, 0, 0, 0});

        // Constant input.
        restart();
        for (int i = 0; i < 6; i++) feed(400);
        idle(); idle();
        expect_seq("constant", '{400, 400, 100, 100, 100, 100});

        // Saturation at both rails.
        restart();
        feed(16383); feed(0); feed(-16384); feed(0); idle(); idle();
        expect_seq("sat_low", '{16383, 0, -16384, 0});
        restart();
        feed(-16384); feed(0); feed(16383); feed(0); idle(); idle();
        expect_seq("sat_high", '{-16384, 0, 16383, 0});

        // Floor rounding of negative history.
        restart();
        feed(-3); feed(0); feed(0); feed(0); idle(); idle();
        expect_seq("floor", '{-3, 0, 3, 0});

        // Gaps in in_valid.
        restart();
        feed(8); idle(); idle(); feed(4); idle(); idle(); feed(8); feed(4); idle(); idle();
        expect_seq("gaps", '{8, 4, 2, 1});

        // Reset mid-pair discards the pending even sample.
        restart();
        feed(500);
        step(1'b1, 1'b0, 0);
        feed(100); feed(200); idle(); idle();
        expect_seq("reset_mid_pair", '{100, 200});

        // Reset cancels a buffered odd result before it is emitted.
        restart();
        feed(50); feed(60);
        step(1'b1, 1'b0, 0);
        idle(); idle(); idle();
        check("reset_cancel_count", got.size(), 0);

        // Pending even sample with no odd partner stays silent.
        restart();
        feed(77);
        for (int i = 0; i < 20; i++) idle();
        check("pending_silent", got.size(), 0);

        // Randomized traffic with occasional resets and extreme samples.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       yv = XMAX;
                1:       yv = XMIN;
                default: yv = int'($urandom_range(0, 32767)) - 16384;
            endcase
            if ($urandom_range(0, 99) == 0) step(1'b1, $urandom_range(0, 1) == 1, yv);
            else step(1'b0, $urandom_range(0, 3) != 0, yv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/iir_par_inv.md
IIR_PAR_INV -- requirements
Module: iir_par_inv

Interface
REQ-001 Parameter: W, default 14, sample bit width minus one (samples are W+1 bits, two's complement).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 y_in  input  W+1  signed filtered sample stream, even/odd interleaved.
REQ-005 in_valid  input  1  y_in is accepted on any rising edge where in_valid=1 and reset=0.
REQ-006 x_out  output  W+1  signed reconstructed sample.
REQ-007 out_valid  output  1  x_out holds a new sample for exactly this cycle.
REQ-008 out_phase  output  1  0 = x_out is an even-index sample, 1 = odd-index sample.

Function
REQ-009 Block SHALL implement the inverse of the two-phase IIR y[n] = x[n] + 0.75*y[n-2]: x[n] = y[n] - (y[n-2]>>>1) - (y[n-2]>>>2), n counted over accepted samples only.
REQ-010 Shifts SHALL be arithmetic (floor toward minus infinity); intermediate sum SHALL be W+3 bits signed, no internal overflow.
REQ-011 Result SHALL saturate to [-2^W, 2^W-1] before driving x_out.
REQ-012 Input demux FSM SHALL have two states, EVEN and ODD; it toggles only on accepted samples; in_valid=0 holds state.
REQ-013 In EVEN, accepted sample SHALL be stored as pending even sample ye.
REQ-014 In ODD, accepted sample yo SHALL complete a pair; on that edge both phase results SHALL be computed from (ye, yo) and prior-pair history (ye_d, yo_d), and history SHALL update to ye_d<=ye, yo_d<=yo.
REQ-015 Even-phase result uses ye_d only; odd-phase result uses yo_d only; phases never mix.
REQ-016 Pair completing on edge t: edge t+1 SHALL present even result (out_valid=1, out_phase=0); edge t+2 SHALL present odd result (out_valid=1, out_phase=1).
REQ-017 Odd result SHALL be buffered so it is emitted at t+2 regardless of in_valid at t+1 or t+2.
REQ-018 With continuous in_valid=1, out_valid SHALL be 1 every cycle after the first 2 cycles, phases alternating 0,1,0,1.
REQ-019 Latency: y[2k] -> x[2k] 2 edges after y[2k+1] accept edge minus 1 (i.e. edge t+1); y[2k+1] -> x[2k+1] at edge t+2.
REQ-020 When out_valid=0, x_out and out_phase SHALL hold their last values.
REQ-021 A pending even sample with no following odd sample SHALL remain pending indefinitely (no timeout, no output).

Reset
REQ-022 On reset: FSM=EVEN, ye, ye_d, yo_d, odd buffer = 0, x_out=0, out_valid=0, out_phase=0.
REQ-023 Reset mid-pair (FSM=ODD) SHALL discard the pending even sample; first sample after reset is index 0 (even).
REQ-024 Reset SHALL cancel a buffered odd result not yet emitted; out_valid=0 on the cycle after reset is sampled.
REQ-025 Reset takes priority over in_valid on the same edge; the sample is not accepted.

Verification
REQ-026 Impulse, W=14, continuous valid: y = 1000,0,0,0,0,0 -> x = 1000,0,-750,0,0,0, out_phase 0,1,0,1,0,1.
REQ-027 Constant: y = 400 continuous -> x = 400,400,100,100,100,... .
REQ-028 Saturation: y = 16383,0,-16384,0 -> x[2] = -16384 (raw -28670); y = -16384,0,16383,0 -> x[2] = 16383 (raw 28671).
REQ-029 Floor rounding: y = -3,0,0,0 -> x = -3,0,3,0.
REQ-030 Gaps: in_valid = 1,0,0,1,0,0,1,1 with y = 8,-,-,4,-,-,8,4 -> outputs x = 8 (edge after 4th cycle), 4 (next edge), then 2,1 after final pair; out_valid 0 elsewhere.
REQ-031 Reset mid-pair: accept y=500 (even), assert reset one cycle, then feed 100,200 -> x = 100,200 with no trace of 500; history zero.
